// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 VGA timing generator and pixel output stage.
// Issues x/y scan coordinates to the overlay layers and drives the VGA pins.
//
// Ports:
//   clk         system clock (CLK_DIV clks per pixel)
//   rst         asynchronous active-high reset
//   rgb_in      composited pixel {R,G,B} for the current x,y
//   x, y        registered scan position, stable for a whole pixel period
//   video_on    x,y lies inside the visible area
//   pixel_tick  one-clk strobe on the last clk of each pixel period
//   frame_start one-clk strobe on the tick of the last pixel of a frame
//   hs, vs      registered syncs, active low, aligned with vga_r/g/b
//   vga_r/g/b   registered colour, one pixel behind x,y
//
// Build option: define VGA_TEST_PATTERN_EN to replace rgb_in with eight
// vertical colour bars, 80 pixels each.
module vga_scan_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  logic          tick;
  logic          vis;
  logic          x_end;
  logic          y_end;
  logic          hs_raw;
  logic          vs_raw;
  logic [11:0]   pix_src;

  assign tick  = (div_q == DIV_LAST);
  assign x_end = (x_q == X_LAST);
  assign y_end = (y_q == Y_LAST);
  assign vis   = (x_q < X_VIS) && (y_q < Y_VIS);

  assign hs_raw = ~((x_q >= HS_START) && (x_q < HS_END));
  assign vs_raw = ~((y_q >= VS_START) && (y_q < VS_END));

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  logic       unused_rgb;

  assign unused_rgb = ^rgb_in;

  // bar = x/80 as a compare chain, avoiding a divider
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_q >= 10'(80 * i)) begin
        bar = 3'(i);
      end
    end
  end

  always_comb begin
    pix_src = 12'h000;
    unique case (bar)
      3'd0: pix_src = 12'hFFF;
      3'd1: pix_src = 12'hFF0;
      3'd2: pix_src = 12'h0FF;
      3'd3: pix_src = 12'h0F0;
      3'd4: pix_src = 12'hF0F;
      3'd5: pix_src = 12'hF00;
      3'd6: pix_src = 12'h00F;
      3'd7: pix_src = 12'h000;
      default: pix_src = 12'h000;
    endcase
  end
`else
  assign pix_src = rgb_in;
`endif

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_end) begin
        x_d = 10'd0;
        y_d = y_end ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Output stage samples only on the tick clk, so rgb_in may glitch
  // freely during the rest of the pixel period.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick) begin
      rgb_d = vis ? pix_src : 12'h000;
      hs_d  = hs_raw;
      vs_d  = vs_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= 10'd0;
      y_q   <= 10'd0;
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = vis;
  assign pixel_tick  = tick;
  assign frame_start = tick && x_end && y_end;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: clock-count model of the scan controller plus
// hand-computed checkpoints; vertical timing is shortened to 8 lines.
module tb_vga_scan_ctrl;

  localparam int CD  = 4;
  localparam int HT  = 800;
  localparam int VV  = 4;
  localparam int VT  = 8;
  localparam int VS0 = 5;
  localparam int VS1 = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgb_in = 12'h000;
  logic [9:0]  x, y;
  logic        video_on, pixel_tick, frame_start, hs, vs;
  logic [3:0]  vga_r, vga_g, vga_b;

  int errors = 0;
  int checks = 0;

  vga_scan_ctrl #(
    .CLK_DIV(CD), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96),
    .H_BACK(48), .V_VISIBLE(VV), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
    .x(x), .y(y), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_start(frame_start),
    .hs(hs), .vs(vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bar_col(input int px);
    logic [11:0] t [8];
    t = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
          12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return t[(px / 80) % 8];
  endfunction

  // Model: everything follows from m_n, the number of clk edges since reset.
  int          m_n   = 0;
  logic [11:0] m_rgb = 12'h000;
  logic        m_hs  = 1'b1;
  logic        m_vs  = 1'b1;

  always @(posedge clk or posedge rst) begin
    int p, px, py;
    if (rst) begin
      m_n   = 0;
      m_rgb = 12'h000;
      m_hs  = 1'b1;
      m_vs  = 1'b1;
    end else begin
      if (m_n % CD == CD - 1) begin
        p  = m_n / CD;
        px = p % HT;
        py = (p / HT) % VT;
        m_hs = !(px >= 656 && px < 752);
        m_vs = !(py >= VS0 && py < VS1);
`ifdef VGA_TEST_PATTERN_EN
        m_rgb = (px < 640 && py < VV) ? bar_col(px) : 12'h000;
`else
        m_rgb = (px < 640 && py < VV) ? rgb_in : 12'h000;
`endif
      end
      m_n++;
    end
  end

  // Stimulus: glitchy random values off the tick, directed values on it.
  always @(negedge clk) begin
    int p;
    p = m_n / CD;
`ifdef VGA_TEST_PATTERN_EN
    rgb_in = 12'h000;
`else
    if (m_n % CD == CD - 1) begin
      if (p == 810)      rgb_in = 12'hA5C;
      else if (p == 820) rgb_in = 12'h123;
      else if (p == 700) rgb_in = 12'hFFF;
      else               rgb_in = 12'(p * 499) ^ 12'h5A5;
    end else begin
      rgb_in = 12'($urandom);
    end
`endif
  end

  int fs_cnt = 0;
  int fs_n   = -1;

  always @(negedge clk) begin
    int p, px, py;
    logic [35:0] got, exp;
    p  = m_n / CD;
    px = p % HT;
    py = (p / HT) % VT;
    exp = {10'(px), 10'(py), (px < 640 && py < VV),
           (m_n % CD == CD - 1),
           (m_n % CD == CD - 1 && px == HT - 1 && py == VT - 1),
           m_hs, m_vs, m_rgb};
    got = {x, y, video_on, pixel_tick, frame_start,
           hs, vs, vga_r, vga_g, vga_b};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL scan n=%0d got=%h want=%h", m_n, got, exp);
    end
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_n = m_n;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s n=%0d got=%h want=%h", nm, m_n, act, req);
    end
  endtask

  task automatic step_to(input int k);
    int guard = 0;
    while (m_n < k && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    chk("step_to", m_n, k);
  endtask

  function automatic logic [11:0] rgb_o();
    return {vga_r, vga_g, vga_b};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_vid", video_on, 1);
    chk("rst_tick", pixel_tick, 0);
    chk("rst_sync", {hs, vs}, 2'b11);
    chk("rst_rgb", rgb_o(), 0);
    rst = 1'b0;

    step_to(3);
    chk("first_tick", pixel_tick, 1);
    chk("first_tick_x", x, 0);
    step_to(4);
    chk("x1", x, 1);
    chk("x1_tick", pixel_tick, 0);
`ifdef VGA_TEST_PATTERN_EN
    chk("pat_x0", rgb_o(), 12'hFFF);
    step_to(344);
    chk("pat_x85", rgb_o(), 12'hFF0);
    step_to(2560);
    chk("pat_x639", rgb_o(), 12'h000);
`endif
    step_to(2627);
    chk("hs_pre", hs, 1);
    step_to(2628);
    chk("hs_fall", hs, 0);
    step_to(2804);
    chk("blank_x700", rgb_o(), 0);
    step_to(3011);
    chk("hs_last", hs, 0);
    step_to(3012);
    chk("hs_rise", hs, 1);
    step_to(3199);
    chk("wrap_pre", {x, y}, {10'd799, 10'd0});
    step_to(3200);
    chk("wrap_post", {x, y}, {10'd0, 10'd1});
`ifndef VGA_TEST_PATTERN_EN
    step_to(3244);
    chk("lat_A5C", {vga_r, vga_g, vga_b}, 12'hA5C);
    step_to(3284);
    chk("glitch_123", rgb_o(), 12'h123);
`endif
    step_to(5828);
    chk("hs_period", hs, 0);
    step_to(16003);
    chk("vs_pre", vs, 1);
    step_to(16004);
    chk("vs_fall", vs, 0);
    step_to(22403);
    chk("vs_last", vs, 0);
    step_to(22404);
    chk("vs_rise", vs, 1);
    step_to(25599);
    chk("frame_start", frame_start, 1);
    step_to(25600);
    chk("frame_wrap", {x, y}, 0);
    chk("fs_once", fs_cnt, 1);
    chk("fs_at", fs_n, 25599);

    step_to(25600 + CD * (2 * HT + 300) + 2);
    chk("mid_pos", {x, y}, {10'd300, 10'd2});
    #1 rst = 1'b1;
    #1;
    chk("ar_xy", {x, y}, 0);
    chk("ar_sync", {hs, vs}, 2'b11);
    chk("ar_rgb", rgb_o(), 0);
    chk("ar_flags", {video_on, pixel_tick, frame_start}, 3'b100);
    repeat (2) @(negedge clk);
    chk("ar_hold", {x, y}, 0);
    rst = 1'b0;
    step_to(20);
    chk("restart", {x, y}, {10'd5, 10'd0});
    step_to(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
